// File: rtl/pc_pkg.sv
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared constants and types for the program-counter unit:
//                default reset/exception vectors, instruction-memory window
//                and the PC sequencer state type.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_pkg;

    // Default vectors; the PC unit exposes these as overridable parameters
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_4180;
    localparam logic [31:0] DEFAULT_IMEM_BASE    = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_IMEM_END     = 32'h0000_6FFC;

    // RUN: normal fetch; PEND: a redirect is buffered behind a stall
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        PEND = 1'b1
    } pc_state_t;

endpackage

`default_nettype wire

// File: rtl/pc_redirect_buf.sv
// ============================================================================
//  Module      : pc_redirect_buf
//  Description : One-entry holding register for a branch/jump target that
//                arrived while fetch was stalled. Load overwrites any older
//                entry; clear discards it; consume marks it used.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_redirect_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic             consume,
    input  logic [WIDTH-1:0] load_target,
    output logic [WIDTH-1:0] target,
    output logic             valid
);

    // Pending target and its valid flag; load has priority over clear/consume
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            target <= '0;
            valid  <= 1'b0;
        end else if (load) begin
            target <= load_target;
            valid  <= 1'b1;
        end else if (clear) begin
            target <= '0;
            valid  <= 1'b0;
        end else if (consume) begin
            valid  <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
// ============================================================================
//  Module      : pc_unit
//  Description : Program counter for the pipelined MIPS fetch stage. Selects
//                the next PC from exception entry, exception return, branch
//                redirect, a buffered redirect, or sequential increment, and
//                buffers a redirect that lands during a stall.
//                Optional fetch-address check enabled by PC_ALIGN_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEFAULT_EXC_VECTOR),
    parameter logic [WIDTH-1:0] IMEM_BASE    = WIDTH'(DEFAULT_IMEM_BASE),
    parameter logic [WIDTH-1:0] IMEM_END     = WIDTH'(DEFAULT_IMEM_END)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             exc_req,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             pend_valid,
    output logic             fetch_exc
);

    pc_state_t        state;
    pc_state_t        next_state;
    logic [WIDTH-1:0] pc_next;
    logic             buf_load;
    logic             buf_clear;
    logic             buf_consume;
    logic [WIDTH-1:0] buf_target;
    logic             buf_valid;

    // Sequential increment wraps naturally modulo 2^WIDTH
    assign pc_plus4 = pc + WIDTH'(4);

    pc_redirect_buf #(
        .WIDTH (WIDTH)
    ) u_redirect_buf (
        .clk         (clk),
        .reset       (reset),
        .load        (buf_load),
        .clear       (buf_clear),
        .consume     (buf_consume),
        .load_target (redirect_target),
        .target      (buf_target),
        .valid       (buf_valid)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and next-PC selection in fixed priority order
    always_comb begin
        next_state  = state;
        pc_next     = pc;
        buf_load    = 1'b0;
        buf_clear   = 1'b0;
        buf_consume = 1'b0;
        if (exc_req) begin
            pc_next    = EXC_VECTOR;
            buf_clear  = 1'b1;
            next_state = RUN;
        end else if (eret) begin
            pc_next    = epc;
            buf_clear  = 1'b1;
            next_state = RUN;
        end else if (redirect && !stall) begin
            pc_next    = redirect_target;
            buf_clear  = 1'b1;
            next_state = RUN;
        end else if (redirect) begin
            // Hold the PC; newest target replaces any older buffered one
            buf_load   = 1'b1;
            next_state = PEND;
        end else if ((state == PEND) && buf_valid && !stall) begin
            pc_next     = buf_target;
            buf_consume = 1'b1;
            next_state  = RUN;
        end else if (!stall) begin
            pc_next = pc_plus4;
        end
    end

    // Outputs derived from state
    always_comb begin
        pend_valid = (state == PEND);
    end

    // Fetch address register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_VECTOR;
        end else begin
            pc <= pc_next;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // Flag misaligned or out-of-window fetch addresses for CP0
    assign fetch_exc = (pc[1:0] != 2'b00) || (pc < IMEM_BASE) || (pc > IMEM_END);
`else
    assign fetch_exc = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// ============================================================================
//  Module      : tb_pc_unit
//  Description : Self-checking bench for pc_unit: directed scenarios followed
//                by randomized traffic against a behavioural PC model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_unit;

    localparam logic [31:0] RST_VEC  = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
    localparam logic [31:0] MEM_LO   = 32'h0000_3000;
    localparam logic [31:0] MEM_HI   = 32'h0000_6FFC;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pend_valid;
    logic        fetch_exc;

    int n_cmp;
    int n_err;

    // Reference model state: current PC and a queue of buffered targets
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];

    pc_unit dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .exc_req         (exc_req),
        .eret            (eret),
        .epc             (epc),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .pend_valid      (pend_valid),
        .fetch_exc       (fetch_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic exp_fexc(input logic [31:0] a);
`ifdef PC_ALIGN_CHECK_EN
        return (a % 4 != 0) || (a < MEM_LO) || (a > MEM_HI);
`else
        return 1'b0;
`endif
    endfunction

    // Apply the next-PC rules to the model using the inputs currently driven
    task automatic model_edge();
        if (exc_req) begin
            m_pc = EXC_VEC;
            m_pend.delete();
        end else if (eret) begin
            m_pc = epc;
            m_pend.delete();
        end else if (redirect && !stall) begin
            m_pc = redirect_target;
            m_pend.delete();
        end else if (redirect) begin
            m_pend.delete();
            m_pend.push_back(redirect_target);
        end else if (m_pend.size() != 0 && !stall) begin
            m_pc = m_pend.pop_front();
        end else if (!stall) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},   pc,                 m_pc);
        check({tag, ".pc4"},  pc_plus4,           m_pc + 32'd4);
        check({tag, ".pend"}, 32'(pend_valid),    32'(m_pend.size() != 0));
        check({tag, ".fexc"}, 32'(fetch_exc),     32'(exp_fexc(m_pc)));
    endtask

    task automatic drive(input logic s, input logic r, input logic [31:0] t,
                         input logic x, input logic e, input logic [31:0] ep);
        stall = s; redirect = r; redirect_target = t;
        exc_req = x; eret = e; epc = ep;
    endtask

    // Inputs are driven just after a falling edge; the rising edge consumes
    // them and results are checked on the following falling edge.
    task automatic cycle(input string tag);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        m_pc = RST_VEC;
        m_pend.delete();
        repeat (2) @(negedge clk);
        check_all("reset");
        check("reset.pc_const", pc, 32'h0000_3000);
        check("reset.pc4_const", pc_plus4, 32'h0000_3004);

        // Reset release and sequential run
        reset = 1'b1;
        cycle("run1");
        cycle("run2");
        check("run2.pc_const", pc, 32'h0000_3008);

        // Redirect captured during a 3-cycle stall
        drive(1, 1, 32'h0000_3100, 0, 0, 0);
        cycle("stl_redir");
        check("stl_redir.pend_const", 32'(pend_valid), 32'd1);
        drive(1, 0, 0, 0, 0, 0);
        cycle("stl2");
        cycle("stl3");
        drive(0, 0, 0, 0, 0, 0);
        cycle("stl_rel");
        check("stl_rel.pc_const", pc, 32'h0000_3100);
        cycle("stl_after");
        check("stl_after.pc_const", pc, 32'h0000_3104);

        // New redirect on the release cycle beats the buffered target
        drive(1, 1, 32'h0000_3300, 0, 0, 0);
        cycle("pend_old");
        drive(0, 1, 32'h0000_3200, 0, 0, 0);
        cycle("pend_new");
        check("pend_new.pc_const", pc, 32'h0000_3200);

        // Priority clash with a pending entry present
        drive(1, 1, 32'h0000_3400, 0, 0, 0);
        cycle("clash_pre");
        drive(1, 1, 32'h0000_3500, 1, 1, 32'h0000_3600);
        cycle("clash");
        check("clash.pc_const", pc, 32'h0000_4180);
        check("clash.pend_const", 32'(pend_valid), 32'd0);

        // Run to 0x4190 then return from exception
        drive(0, 0, 0, 0, 0, 0);
        repeat (4) cycle("to4190");
        drive(0, 0, 0, 0, 1, 32'h0000_3020);
        cycle("eret");
        check("eret.pc_const", pc, 32'h0000_3020);

        // Wrap-around of the increment
        drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        cycle("wrap_pre");
        drive(0, 0, 0, 0, 0, 0);
        cycle("wrap");
        check("wrap.pc_const", pc, 32'h0000_0000);

        // Fetch-address check targets
        drive(0, 1, 32'h0000_3102, 0, 0, 0);
        cycle("chk_3102");
        drive(0, 1, 32'h0000_7000, 0, 0, 0);
        cycle("chk_7000");
        drive(0, 1, 32'h0000_3104, 0, 0, 0);
        cycle("chk_3104");
        check("chk_3104.fexc_const", 32'(fetch_exc), 32'd0);

        // Asynchronous reset while a redirect is pending
        drive(1, 1, 32'h0000_3800, 0, 0, 0);
        cycle("arst_pre");
        #2 reset = 1'b0;
        #1;
        check("arst.pc", pc, 32'h0000_3000);
        check("arst.pend", 32'(pend_valid), 32'd0);
        m_pc = RST_VEC;
        m_pend.delete();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_all("arst_hold");
        reset = 1'b1;
        cycle("arst_rel");

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] t;
            logic [31:0] e;
            t = 32'h0000_3000 + ($urandom_range(0, 32'h1000) & ~32'h3);
            e = 32'h0000_3000 + ($urandom_range(0, 32'h1000) & ~32'h3);
            if ($urandom_range(0, 15) == 0) t = $urandom;
            drive($urandom_range(0, 9) < 4,
                  $urandom_range(0, 3) == 0, t,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 19) == 0, e);
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
